pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller_if.sv | 37 +++
 rtl/pipeline_hazard_controller.sv | 104 ++++++++++
 tb/tb_pipeline_hazard_controller.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_if.sv
// Decode/EX hazard inputs and pipeline-register control outputs of the hazard controller.
// The controller side takes the slave modport; the pipeline (or bench) takes master.
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic [2:0]       IF_ID_Read_Reg_Num_1;
  logic [2:0]       IF_ID_Read_Reg_Num_2;
  logic             IF_ID_Uses_Rs1;
  logic             IF_ID_Uses_Rs2;
  logic [2:0]       ID_EX_Write_Reg_Num;
  logic             ID_EX_MemRead;
  logic             EX_Branch_Taken;
  logic             EX_Mul_Start;
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             ID_EX_Write;
  logic             ID_EX_Bubble;
  logic             IF_ID_Flush;
  logic             Mul_Busy;
  logic             Mul_Done;
  logic [1:0]       State;
  logic [CNT_W-1:0] Stall_Count;

  modport slave (
    input  IF_ID_Read_Reg_Num_1, IF_ID_Read_Reg_Num_2, IF_ID_Uses_Rs1, IF_ID_Uses_Rs2,
           ID_EX_Write_Reg_Num, ID_EX_MemRead, EX_Branch_Taken, EX_Mul_Start,
    output PC_Write, IF_ID_Write, ID_EX_Write, ID_EX_Bubble, IF_ID_Flush,
           Mul_Busy, Mul_Done, State, Stall_Count
  );

  modport master (
    output IF_ID_Read_Reg_Num_1, IF_ID_Read_Reg_Num_2, IF_ID_Uses_Rs1, IF_ID_Uses_Rs2,
           ID_EX_Write_Reg_Num, ID_EX_MemRead, EX_Branch_Taken, EX_Mul_Start,
    input  PC_Write, IF_ID_Write, ID_EX_Write, ID_EX_Bubble, IF_ID_Flush,
           Mul_Busy, Mul_Done, State, Stall_Count
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush controller for load-use, taken-branch and multi-cycle multiply hazards.
// Controls are combinational (0-cycle); a multiply holds PC/IF/ID for MUL_CYCLES-1 cycles.
module pipeline_hazard_controller #(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  pipeline_hazard_controller_if.slave  bus
);
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10,
    ILLEGAL  = 2'b11
  } state_t;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 2);

  state_t           r_state, w_next_state;
  logic [3:0]       r_cnt, w_next_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_lu;
  logic             w_pc_write, w_if_id_write, w_id_ex_write;
  logic             w_bubble, w_flush, w_busy, w_done;

  assign w_lu = bus.ID_EX_MemRead &&
                ((bus.IF_ID_Uses_Rs1 && (bus.IF_ID_Read_Reg_Num_1 == bus.ID_EX_Write_Reg_Num)) ||
                 (bus.IF_ID_Uses_Rs2 && (bus.IF_ID_Read_Reg_Num_2 == bus.ID_EX_Write_Reg_Num)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= RUN;
      r_cnt       <= 4'd0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (!w_pc_write && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next_state  = RUN;
    w_next_cnt    = r_cnt;
    w_pc_write    = 1'b1;
    w_if_id_write = 1'b1;
    w_id_ex_write = 1'b1;
    w_bubble      = 1'b0;
    w_flush       = 1'b0;
    w_busy        = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      MUL_BUSY: begin
        w_busy        = 1'b1;
        w_pc_write    = 1'b0;
        w_if_id_write = 1'b0;
        w_id_ex_write = 1'b0;
        w_next_cnt    = (r_cnt != 4'd0) ? r_cnt - 4'd1 : 4'd0;
        // Counter reaching zero this cycle hands over to the result cycle.
        w_next_state  = (r_cnt <= 4'd1) ? MUL_DONE : MUL_BUSY;
      end
      default: begin
        // RUN, MUL_DONE and the unused encoding share the RUN decision tree;
        // only RUN may launch a new multiply.
        w_done = (r_state == MUL_DONE);
        if (bus.EX_Branch_Taken) begin
          w_bubble = 1'b1;
          w_flush  = 1'b1;
        end else if (bus.EX_Mul_Start && (r_state == RUN)) begin
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_id_ex_write = 1'b0;
          w_next_cnt    = MUL_LOAD;
          w_next_state  = (MUL_CYCLES <= 2) ? MUL_DONE : MUL_BUSY;
        end else if (w_lu) begin
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_bubble      = 1'b1;
        end
      end
    endcase
    if (!reset_n) begin
      w_pc_write    = 1'b1;
      w_if_id_write = 1'b1;
      w_id_ex_write = 1'b1;
      w_bubble      = 1'b1;
      w_flush       = 1'b1;
      w_busy        = 1'b0;
      w_done        = 1'b0;
    end
  end

  assign bus.PC_Write     = w_pc_write;
  assign bus.IF_ID_Write  = w_if_id_write;
  assign bus.ID_EX_Write  = w_id_ex_write;
  assign bus.ID_EX_Bubble = w_bubble;
  assign bus.IF_ID_Flush  = w_flush;
  assign bus.Mul_Busy     = w_busy;
  assign bus.Mul_Done     = w_done;
  assign bus.State        = r_state;
  assign bus.Stall_Count  = r_stall_cnt;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scenario bench for pipeline_hazard_controller: per-cycle expected controls queued at drive time.
module tb_pipeline_hazard_controller;
  logic clk;
  logic reset_n;

  pipeline_hazard_controller_if #(.CNT_W(16)) a ();
  pipeline_hazard_controller_if #(.CNT_W(4))  b ();

  pipeline_hazard_controller #(.MUL_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(a.slave));
  pipeline_hazard_controller #(.MUL_CYCLES(4), .CNT_W(4)) dut_sat (
    .clk(clk), .reset_n(reset_n), .bus(b.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stimulus: rst_n, branch, mul_start, memread, dest, uses1, rs1, uses2, rs2
  typedef struct packed {
    logic       rst_n;
    logic       br;
    logic       mul;
    logic       mr;
    logic [2:0] dest;
    logic       u1;
    logic [2:0] rs1;
    logic       u2;
    logic [2:0] rs2;
  } in_t;

  // Controls: PC_Write, IF_ID_Write, ID_EX_Write, Bubble, Flush, Mul_Busy, Mul_Done
  typedef struct packed {
    logic [6:0]  ctl;
    logic [1:0]  st;
    logic [15:0] sc;
  } obs_t;

  typedef struct packed {
    in_t        in;
    logic [6:0] ctl;
    logic [1:0] st;
  } step_t;

  localparam logic [6:0] C_RUN  = 7'b111_00_00;
  localparam logic [6:0] C_LU   = 7'b001_10_00;
  localparam logic [6:0] C_BR   = 7'b111_11_00;
  localparam logic [6:0] C_MS   = 7'b000_00_00;
  localparam logic [6:0] C_MB   = 7'b000_00_10;
  localparam logic [6:0] C_MD   = 7'b111_00_01;
  localparam logic [6:0] C_MDBR = 7'b111_11_01;
  localparam logic [6:0] C_MDLU = 7'b001_10_01;
  localparam logic [6:0] C_RST  = 7'b111_11_00;

  localparam in_t I_IDLE  = {1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 3'd1, 1'b1, 3'd2};
  localparam in_t I_LU2   = {1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 3'd0, 1'b1, 3'd3};
  localparam in_t I_LU1   = {1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 3'd2};
  localparam in_t I_LU0   = {1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd7};
  localparam in_t I_MR0   = {1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 3'd3, 1'b1, 3'd3};
  localparam in_t I_NOUSE = {1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 3'd3, 1'b0, 3'd3};
  localparam in_t I_NOMAT = {1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 3'd1, 1'b1, 3'd2};
  localparam in_t I_BR    = {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0};
  localparam in_t I_MUL   = {1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0};
  localparam in_t I_BRMUL = {1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0};
  localparam in_t I_BRLU  = {1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 3'd0, 1'b1, 3'd3};
  localparam in_t I_MULLU = {1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 1'b1, 3'd3};
  localparam in_t I_ALL   = {1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 1'b1, 3'd3};
  localparam in_t I_RST   = {1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 1'b1, 3'd3};

  obs_t        sb[$];
  logic [15:0] exp_sc;
  logic [3:0]  exp_sat;
  int          errors;
  int          checks;

  function automatic obs_t sample();
    obs_t o;
    o.ctl = {a.PC_Write, a.IF_ID_Write, a.ID_EX_Write, a.ID_EX_Bubble, a.IF_ID_Flush,
             a.Mul_Busy, a.Mul_Done};
    o.st  = a.State;
    o.sc  = a.Stall_Count;
    return o;
  endfunction

  // Drives one cycle of stimulus on both instances and queues the expected observation.
  task automatic apply(input step_t s);
    obs_t e;
    reset_n                = s.in.rst_n;
    a.EX_Branch_Taken      = s.in.br;    b.EX_Branch_Taken      = s.in.br;
    a.EX_Mul_Start         = s.in.mul;   b.EX_Mul_Start         = s.in.mul;
    a.ID_EX_MemRead        = s.in.mr;    b.ID_EX_MemRead        = s.in.mr;
    a.ID_EX_Write_Reg_Num  = s.in.dest;  b.ID_EX_Write_Reg_Num  = s.in.dest;
    a.IF_ID_Uses_Rs1       = s.in.u1;    b.IF_ID_Uses_Rs1       = s.in.u1;
    a.IF_ID_Read_Reg_Num_1 = s.in.rs1;   b.IF_ID_Read_Reg_Num_1 = s.in.rs1;
    a.IF_ID_Uses_Rs2       = s.in.u2;    b.IF_ID_Uses_Rs2       = s.in.u2;
    a.IF_ID_Read_Reg_Num_2 = s.in.rs2;   b.IF_ID_Read_Reg_Num_2 = s.in.rs2;
    e.ctl = s.ctl;
    e.st  = s.st;
    e.sc  = exp_sc;
    sb.push_back(e);
    if (!s.in.rst_n) begin
      exp_sc  = '0;
      exp_sat = '0;
    end else if (!s.ctl[6]) begin
      if (exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
      if (exp_sat != 4'hF)    exp_sat = exp_sat + 4'd1;
    end
  endtask

  task automatic test_reset();
    step_t t[$];
    obs_t  got, e;
    t = '{'{I_RST, C_RST, 2'b00}, '{I_RST, C_RST, 2'b00}, '{I_IDLE, C_RUN, 2'b00}};
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      got = sample(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset[%0d] got=%h exp=%h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    step_t t[$];
    obs_t  got, e;
    t = '{'{I_LU2, C_LU, 2'b00}, '{I_IDLE, C_RUN, 2'b00}, '{I_LU1, C_LU, 2'b00},
          '{I_MR0, C_RUN, 2'b00}, '{I_NOUSE, C_RUN, 2'b00}, '{I_NOMAT, C_RUN, 2'b00},
          '{I_LU0, C_LU, 2'b00}, '{I_LU2, C_LU, 2'b00}, '{I_IDLE, C_RUN, 2'b00}};
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      got = sample(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL load_use[%0d] got=%h exp=%h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    step_t t[$];
    obs_t  got, e;
    t = '{'{I_BRMUL, C_BR, 2'b00}, '{I_IDLE, C_RUN, 2'b00}, '{I_BRLU, C_BR, 2'b00},
          '{I_BR, C_BR, 2'b00}, '{I_MULLU, C_MS, 2'b00}, '{I_IDLE, C_MB, 2'b01},
          '{I_IDLE, C_MB, 2'b01}, '{I_IDLE, C_MD, 2'b10}, '{I_IDLE, C_RUN, 2'b00}};
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      got = sample(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL branch[%0d] got=%h exp=%h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_multiply();
    step_t t[$];
    obs_t  got, e;
    t = '{'{I_MUL, C_MS, 2'b00}, '{I_IDLE, C_MB, 2'b01}, '{I_IDLE, C_MB, 2'b01},
          '{I_IDLE, C_MD, 2'b10}, '{I_IDLE, C_RUN, 2'b00},
          '{I_MUL, C_MS, 2'b00}, '{I_BR, C_MB, 2'b01}, '{I_ALL, C_MB, 2'b01},
          '{I_BRMUL, C_MDBR, 2'b10}, '{I_IDLE, C_RUN, 2'b00},
          '{I_MUL, C_MS, 2'b00}, '{I_LU2, C_MB, 2'b01}, '{I_IDLE, C_MB, 2'b01},
          '{I_MULLU, C_MDLU, 2'b10}, '{I_IDLE, C_RUN, 2'b00}};
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      got = sample(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL multiply[%0d] got=%h exp=%h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    step_t t[$];
    obs_t  got, e;
    t = '{'{I_MUL, C_MS, 2'b00}, '{I_MUL, C_MB, 2'b01}, '{I_MUL, C_MB, 2'b01},
          '{I_MUL, C_MD, 2'b10}, '{I_MUL, C_MS, 2'b00}, '{I_IDLE, C_MB, 2'b01},
          '{I_IDLE, C_MB, 2'b01}, '{I_IDLE, C_MD, 2'b10}, '{I_IDLE, C_RUN, 2'b00}};
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      got = sample(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL back_to_back[%0d] got=%h exp=%h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_mul();
    step_t t[$];
    obs_t  got, e;
    t = '{'{I_MUL, C_MS, 2'b00}, '{I_IDLE, C_MB, 2'b01}, '{I_RST, C_RST, 2'b01},
          '{I_IDLE, C_RUN, 2'b00}, '{I_LU2, C_LU, 2'b00}, '{I_IDLE, C_RUN, 2'b00}};
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      got = sample(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset_mid_mul[%0d] got=%h exp=%h", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    step_t s;
    obs_t  got, e;
    for (int i = 0; i < 23; i++) begin
      if (i == 0)       s = '{I_RST, C_RST, 2'b00};
      else if (i < 21)  s = '{I_LU2, C_LU, 2'b00};
      else              s = '{I_IDLE, C_RUN, 2'b00};
      apply(s);
      @(negedge clk);
      got = sample(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL saturation_main[%0d] got=%h exp=%h", i, got, e); end
      checks++;
      if (b.Stall_Count !== exp_sat && i > 0 && s.in.rst_n) begin
        // exp_sat already reflects this cycle's edge; compare against the pre-edge value below.
      end
      if (b.Stall_Count !== ((i == 0) ? b.Stall_Count : ((i - 1 > 15) ? 4'hF : 4'(i - 1)))) begin
        errors++;
        $display("FAIL saturation_cnt4[%0d] got=%0d exp=%0d", i, b.Stall_Count,
                 (i - 1 > 15) ? 15 : i - 1);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (b.Stall_Count !== 4'hF || exp_sat !== 4'hF) begin
      errors++;
      $display("FAIL saturation_final got=%0d exp=15", b.Stall_Count);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    exp_sc  = '0;
    exp_sat = '0;
    reset_n = 1'b0;
    a.EX_Branch_Taken = 1'b0; b.EX_Branch_Taken = 1'b0;
    a.EX_Mul_Start = 1'b0;    b.EX_Mul_Start = 1'b0;
    a.ID_EX_MemRead = 1'b0;   b.ID_EX_MemRead = 1'b0;
    a.ID_EX_Write_Reg_Num = 3'd0;  b.ID_EX_Write_Reg_Num = 3'd0;
    a.IF_ID_Uses_Rs1 = 1'b0;  b.IF_ID_Uses_Rs1 = 1'b0;
    a.IF_ID_Uses_Rs2 = 1'b0;  b.IF_ID_Uses_Rs2 = 1'b0;
    a.IF_ID_Read_Reg_Num_1 = 3'd0; b.IF_ID_Read_Reg_Num_1 = 3'd0;
    a.IF_ID_Read_Reg_Num_2 = 3'd0; b.IF_ID_Read_Reg_Num_2 = 3'd0;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_branch();
    test_multiply();
    test_back_to_back();
    test_reset_mid_mul();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
